// File: rtl/jk_ff_race_pkg.sv
// jk_ff_race_pkg: shared JK mode encoding and next-state helper.
// Mode is formed as {j,k}; jk_next() gives the post-edge q for a mode.
package jk_ff_race_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_mode_e;

    function automatic logic jk_next(
        input jk_mode_e mode,
        input logic     q
    );
        logic nq;
        nq = q;
        unique case (mode)
            JK_HOLD:   nq = q;
            JK_RESET:  nq = 1'b0;
            JK_SET:    nq = 1'b1;
            JK_TOGGLE: nq = ~q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/jk_ff_race_cell.sv
// jk_ff_cell: single-bit edge-triggered JK flip-flop with toggle flag.
// Ports: clk, rst (async high), j, k in; q, qn (= ~q), race out.
module jk_ff_cell
    import jk_ff_race_pkg::*;
#(
    parameter logic RST_Q = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qn,
    output logic race
);

    jk_mode_e mode;
    logic     q_q;
    logic     q_d;
    logic     race_q;
    logic     race_d;

    assign mode   = jk_mode_e'({j, k});
    assign q_d    = jk_next(mode, q_q);
    assign race_d = (mode == JK_TOGGLE);

    // Pure edge sampling: one update per rising edge, so no race-around.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= RST_Q;
            race_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            race_q <= race_d;
        end
    end

    assign q    = q_q;
    assign qn   = ~q_q;
    assign race = race_q;

endmodule

// File: rtl/jk_ff_race.sv
// jk_ff_race: WIDTH independent JK flip-flops with per-bit toggle flag.
// Ports: clk, rst (async high), j/k [WIDTH] in; q, qn, race [WIDTH] out.
module jk_ff_race
    import jk_ff_race_pkg::*;
#(
    parameter int               WIDTH = 1,
    parameter logic [WIDTH-1:0] RST_Q = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] race
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        jk_ff_cell #(
            .RST_Q (RST_Q[g])
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .j    (j[g]),
            .k    (k[g]),
            .q    (q[g]),
            .qn   (qn[g]),
            .race (race[g])
        );
    end

endmodule

// File: tb/tb_jk_ff_race.sv
// tb_jk_ff_race: randomized and directed checks of jk_ff_race (WIDTH=4)
// against a per-bit behavioural JK model.
module tb_jk_ff_race;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] q;
    logic [W-1:0] qn;
    logic [W-1:0] race;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq = '0;
    logic [W-1:0] mr = '0;

    jk_ff_race #(
        .WIDTH (W),
        .RST_Q ('0)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .j    (j),
        .k    (k),
        .q    (q),
        .qn   (qn),
        .race (race)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: each bit follows the JK truth table.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq <= '0;
            mr <= '0;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (j[i] && k[i]) begin
                    mq[i] <= !mq[i];
                    mr[i] <= 1'b1;
                end else begin
                    if (j[i])      mq[i] <= 1'b1;
                    else if (k[i]) mq[i] <= 1'b0;
                    mr[i] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("model_q", q, mq);
        check("model_qn", qn, ~mq);
        check("model_race", race, mr);
    end

    task automatic step(input logic [W-1:0] jv, input logic [W-1:0] kv);
        @(negedge clk);
        j = jv;
        k = kv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        j   = '0;
        k   = '0;
        #1;
        check("rst_q", q, 4'b0000);
        check("rst_qn", qn, 4'b1111);
        check("rst_race", race, 4'b0000);
        @(posedge clk);
        #1;
        check("rst_edge_ignored", q, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        // Release with hold for 3 edges
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, 4'b0000);
            check("hold_q", q, 4'b0000);
            check("hold_qn", qn, 4'b1111);
            check("hold_race", race, 4'b0000);
        end

        // Clear then set
        step(4'b0000, 4'b1111);
        check("clr_q", q, 4'b0000);
        check("clr_qn", qn, 4'b1111);
        step(4'b1111, 4'b0000);
        check("set_q", q, 4'b1111);
        check("set_qn", qn, 4'b0000);

        // Sustained toggle from q=1
        for (int i = 0; i < 4; i++) begin
            step(4'b1111, 4'b1111);
            check("tog_q", q, (i % 2 == 0) ? 4'b0000 : 4'b1111);
            check("tog_race", race, 4'b1111);
        end

        // j pulse while clk high must not matter
        step(4'b0000, 4'b0000);
        check("pre_pulse_q", q, 4'b1111);
        step(4'b0000, 4'b1010);
        check("pre_pulse2_q", q, 4'b0101);
        #2 j = 4'b1010;
        #1 check("pulse_mid_q", q, 4'b0101);
        #1 j = 4'b0000;
        @(posedge clk);
        #1;
        check("pulse_q", q, 4'b0101);
        check("pulse_race", race, 4'b0000);

        // Per-bit independence
        step(4'b0011, 4'b1100);
        check("mix_pre_q", q, 4'b0011);
        step(4'b1010, 4'b0110);
        check("mix_q", q, 4'b1001);
        check("mix_race", race, 4'b0010);

        // Async reset mid-toggle
        step(4'b1111, 4'b1111);
        check("art_q", q, 4'b0110);
        #2 rst = 1'b1;
        #1;
        check("ar_q", q, 4'b0000);
        check("ar_qn", qn, 4'b1111);
        check("ar_race", race, 4'b0000);
        @(posedge clk);
        #1;
        check("ar_hold_q", q, 4'b0000);
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("ar_resume_q", q, 4'b1111);
        check("ar_resume_race", race, 4'b1111);

        // Randomized traffic with occasional async reset pulses
        for (int n = 0; n < 300; n++) begin
            step(W'($urandom), W'($urandom));
            if ($urandom_range(0, 19) == 0) begin
                #($urandom_range(1, 3)) rst = 1'b1;
                #1 check("rnd_rst_q", q, 4'b0000);
                check("rnd_rst_race", race, 4'b0000);
                @(negedge clk);
                #1 rst = 1'b0;
            end
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
